// File: rtl/counter_sequencer_if.sv
// Command/status bundle between a run controller (master) and the counter
// sequencer (slave); clock and reset travel as separate scalar ports.
interface counter_sequencer_if #(
  parameter int WIDTH = 4
);
  // There is no valid/ready pair: start is a one-cycle request taken only when
  // the sequencer is idle or done; halt/hold are levels sampled every edge.
  // tc is a one-cycle event strobe the consumer must take on the cycle it is high.
  logic             start;
  logic             halt;
  logic             hold;
  logic             up;
  logic             auto_reload;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;
  logic [3:0]       reloads;
  logic [1:0]       dbg_state;

  modport master (
    output start, halt, hold, up, auto_reload, limit,
    input  count, busy, done, tc, reloads, dbg_state
  );

  modport slave (
    input  start, halt, hold, up, auto_reload, limit,
    output count, busy, done, tc, reloads, dbg_state
  );
endinterface

// File: rtl/counter_sequencer.sv
// Run sequencer for a WIDTH-bit up/down counter: latches a run configuration on
// start, steps once per clock, strobes tc at terminal and optionally auto-reloads.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  counter_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             up_q, up_d;
  logic             auto_q, auto_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       reloads_q, reloads_d;

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;

  // Start/terminal values always come from the latched configuration.
  assign start_val = up_q ? '0 : limit_q;
  assign term_val  = up_q ? limit_q : '0;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    up_d      = up_q;
    auto_d    = auto_q;
    tc_d      = 1'b0;
    reloads_d = reloads_q;

    if (bus.halt) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            up_d      = bus.up;
            auto_d    = bus.auto_reload;
            limit_d   = bus.limit;
            count_d   = bus.up ? '0 : bus.limit;
            reloads_d = 4'd0;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (bus.hold) begin
            state_d = PAUSE;
          end else if (count_q == term_val) begin
            tc_d = 1'b1;
            if (auto_q) begin
              count_d   = start_val;
              reloads_d = (reloads_q == 4'd15) ? 4'd15 : reloads_q + 4'd1;
            end else begin
              state_d = DONE;
            end
          end else if (up_q) begin
            count_d = count_q + ONE;
          end else begin
            count_d = count_q - ONE;
          end
        end
        PAUSE: begin
          // Resuming costs one edge: no step on the PAUSE->RUN transition.
          if (!bus.hold) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      limit_q   <= '0;
      up_q      <= 1'b0;
      auto_q    <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      reloads_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      up_q      <= up_d;
      auto_q    <= auto_d;
      tc_q      <= tc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      reloads_q <= reloads_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tc        = tc_q;
  assign bus.reloads   = reloads_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: each driven cycle queues its hand-derived
// expected outputs; a monitor compares them one per clock edge.
module tb_counter_sequencer;

  localparam int W = 4;

  logic clock;
  logic reset;

  counter_sequencer_if #(.WIDTH(W)) bus ();

  counter_sequencer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  // packed {count, busy, done, tc, reloads}
  logic [10:0] exp_q[$];
  string       name_q[$];
  int          n_compared;
  int          n_mismatched;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
  end

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      logic [10:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.count, bus.busy, bus.done, bus.tc, bus.reloads};
      n_compared++;
      if (a !== e) begin
        n_mismatched++;
        $display("FAIL %s: got count=%0d busy=%b done=%b tc=%b reloads=%0d, expected count=%0d busy=%b done=%b tc=%b reloads=%0d",
                 nm, a[10:7], a[6], a[5], a[4], a[3:0], e[10:7], e[6], e[5], e[4], e[3:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input string nm, input logic rst_n, input logic st, input logic hl,
                     input logic hd, input logic u, input logic ar, input logic [W-1:0] lim,
                     input logic [W-1:0] e_cnt, input logic e_busy, input logic e_done,
                     input logic e_tc, input logic [3:0] e_rel);
    @(negedge clock);
    reset           = rst_n;
    bus.start       = st;
    bus.halt        = hl;
    bus.hold        = hd;
    bus.up          = u;
    bus.auto_reload = ar;
    bus.limit       = lim;
    exp_q.push_back({e_cnt, e_busy, e_done, e_tc, e_rel});
    name_q.push_back(nm);
  endtask

  // Plain cycle: configuration inputs are scrambled to show they are ignored.
  task automatic run(input string nm, input logic hd, input logic [W-1:0] e_cnt,
                     input logic e_busy, input logic e_done, input logic e_tc,
                     input logic [3:0] e_rel);
    cyc(nm, 1'b1, 1'b0, 1'b0, hd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        W'($urandom_range(0, 15)), e_cnt, e_busy, e_done, e_tc, e_rel);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.halt = 1'b0; bus.hold = 1'b0;
    bus.up = 1'b0; bus.auto_reload = 1'b0; bus.limit = '0;

    // reset with inputs toggling
    cyc("reset0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'd0, 0, 0, 0, 4'd0);
    cyc("reset1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 4'd0, 0, 0, 0, 4'd0);
    run("idle", 1'b1, 4'd0, 0, 0, 0, 4'd0);

    // up, one-shot, limit=5
    cyc("up5_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd0, 1, 0, 0, 4'd0);
    for (int i = 1; i <= 5; i++) run("up5_step", 1'b0, W'(i), 1, 0, 0, 4'd0);
    run("up5_tc", 1'b0, 4'd5, 0, 1, 1, 4'd0);
    run("up5_done0", 1'b0, 4'd5, 0, 1, 0, 4'd0);
    run("up5_done1", 1'b0, 4'd5, 0, 1, 0, 4'd0);

    // down, auto-reload, limit=3: 3,2,1,0 repeating; run past reloads saturation
    cyc("dn3_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 1, 0, 0, 4'd0);
    for (int k = 1; k <= 70; k++) begin
      int ph;
      int rl;
      ph = k % 4;
      rl = (k / 4 > 15) ? 15 : k / 4;
      run("dn3_auto", 1'b0, (ph == 0) ? 4'd3 : W'(3 - ph), 1, 0, (ph == 0), 4'(rl));
    end
    cyc("dn3_halt", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 0, 0, 0, 4'd15);

    // up, limit=7, hold 3 cycles at count=2
    cyc("hold_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 1, 0, 0, 4'd0);
    run("hold_s1", 1'b0, 4'd1, 1, 0, 0, 4'd0);
    run("hold_s2", 1'b0, 4'd2, 1, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) run("hold_paused", 1'b1, 4'd2, 1, 0, 0, 4'd0);
    run("hold_resume", 1'b0, 4'd2, 1, 0, 0, 4'd0);
    for (int c = 3; c <= 7; c++) run("hold_step", 1'b0, W'(c), 1, 0, 0, 4'd0);
    run("hold_tc", 1'b0, 4'd7, 0, 1, 1, 4'd0);

    // start ignored during RUN, then halt+start together at count=4
    cyc("halt_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 1, 0, 0, 4'd0);
    run("halt_s1", 1'b0, 4'd1, 1, 0, 0, 4'd0);
    run("halt_s2", 1'b0, 4'd2, 1, 0, 0, 4'd0);
    cyc("ign_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 1, 0, 0, 4'd0);
    run("halt_s4", 1'b0, 4'd4, 1, 0, 0, 4'd0);
    cyc("halt_w_start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 0, 0, 0, 4'd0);
    run("halt_idle0", 1'b0, 4'd0, 0, 0, 0, 4'd0);
    run("halt_idle1", 1'b0, 4'd0, 0, 0, 0, 4'd0);

    // limit=0 auto-reload: terminal every cycle; halt keeps reloads
    cyc("z_auto_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1, 0, 0, 4'd0);
    run("z_auto_1", 1'b0, 4'd0, 1, 0, 1, 4'd1);
    run("z_auto_2", 1'b0, 4'd0, 1, 0, 1, 4'd2);
    cyc("z_auto_halt", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 0, 0, 0, 4'd2);

    // limit=0 one-shot, then restart from DONE with limit=2 auto-reload
    cyc("z_os_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1, 0, 0, 4'd0);
    run("z_os_tc", 1'b0, 4'd0, 0, 1, 1, 4'd0);
    cyc("l2_restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd0, 1, 0, 0, 4'd0);
    run("l2_s1", 1'b0, 4'd1, 1, 0, 0, 4'd0);
    run("l2_s2", 1'b0, 4'd2, 1, 0, 0, 4'd0);
    run("l2_reload", 1'b0, 4'd0, 1, 0, 1, 4'd1);
    run("l2_s1b", 1'b0, 4'd1, 1, 0, 0, 4'd1);
    cyc("l2_halt", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 0, 0, 0, 4'd1);

    // reset mid-run: no tc, everything cleared
    cyc("rst_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1, 0, 0, 4'd0);
    run("rst_s0", 1'b0, 4'd0, 1, 0, 0, 4'd0);
    run("rst_reload", 1'b0, 4'd1, 1, 0, 1, 4'd1);
    cyc("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 0, 0, 0, 4'd0);
    run("rst_after", 1'b0, 4'd0, 0, 0, 0, 4'd0);

    // drain the scoreboard with a bounded wait
    begin
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
        @(posedge clock);
        guard++;
      end
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        n_mismatched++;
        $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Synchronous controller that sequences a WIDTH-bit counting datapath through programmed runs: it latches a terminal limit, direction and reload mode on a start pulse, steps the count once per clock, and flags terminal count. It supports pause, abort and auto-reload. It replaces ripple-clocked counting wherever software-visible, single-clock-domain timing of count events is required. Downstream logic consumes `tc` as a one-cycle event strobe.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a run; honoured only in IDLE or DONE
- halt  in  1  abort; returns to IDLE from any state
- hold  in  1  level; pauses an active run
- up  in  1  direction, sampled with start (1 = count up)
- auto_reload  in  1  mode, sampled with start (1 = restart at terminal, 0 = one-shot)
- limit  in  WIDTH  terminal magnitude, sampled with start
- count  out  WIDTH  current count value
- busy  out  1  high in RUN or PAUSE
- done  out  1  high in DONE
- tc  out  1  one-cycle terminal-count strobe
- reloads  out  4  auto-reload events since last start, saturating at 15

## Operation
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Reset (reset=0 at an edge): state IDLE; count, tc, reloads and latched up/auto_reload/limit all 0; busy=0, done=0.
- Priority at each edge: reset > halt > start > hold > stepping.
- Start value: `S = up ? 0 : limit_l`. Terminal value: `T = up ? limit_l : 0`, where limit_l is the latched limit.
- IDLE/DONE + start: latch up, auto_reload, limit; count←S; reloads←0; →RUN.
- IDLE + no start: hold all outputs. DONE + no start: remain DONE with count frozen at T.
- RUN, hold=0, count≠T: count←count+1 when up, count−1 when down; no wrap is possible inside a run.
- RUN, hold=0, count==T: tc←1 for the following cycle.
  - auto_reload=1: count←S; reloads←min(reloads+1,15); stay RUN.
  - auto_reload=0: →DONE; count stays T.
- RUN, hold=1: →PAUSE; count unchanged on that edge.
- PAUSE, hold=1: stay, frozen. PAUSE, hold=0: →RUN; no step on that edge.
- halt in any state: →IDLE; count←0; tc←0. reloads is retained.
- start while RUN/PAUSE: ignored; latched configuration is not updated.
- limit=0 is legal: S=T=0, so terminal is detected on the first RUN edge.
- Input changes to up, auto_reload or limit between starts have no effect.

## Timing
- Start sampled at edge E0: count=S and busy=1 from E0.
- With limit=L and no hold, terminal is detected at edge E0+L+1. tc is high for exactly one cycle after that edge.
- One-shot: done=1 and busy=0 from E0+L+1.
- Auto-reload period: L+1 cycles per terminal; tc pulses every L+1 cycles.
- Each cycle spent in PAUSE delays the terminal by one cycle. Each hold assertion costs one extra cycle, because the PAUSE→RUN edge does not step.
- Start in DONE at the same edge as done=1 restarts immediately: one cycle of done, then busy.
- Reset mid-run takes effect at the next edge regardless of state, with no tc pulse.

## Test plan
- Reset with all inputs toggling → count=0, busy=0, done=0, tc=0, reloads=0 on the cycle after the first reset=0 edge.
- up=1, auto_reload=0, limit=5, start pulse → count 0,1,2,3,4,5, then tc high one cycle and done=1 exactly 6 cycles after start; count holds 5.
- up=0, auto_reload=1, limit=3, run 13 cycles → count 3,2,1,0 repeating; tc every 4 cycles; reloads reaches 3. Continue to saturate → reloads stays 15.
- up=1, limit=7, hold high for 3 cycles at count=2 → count stays 2 for 4 cycles; tc arrives 4 cycles later than the unheld run.
- halt asserted with start in the same cycle during RUN at count=4 → IDLE, count=0, no tc. A start pulse during RUN is ignored and count continues unchanged.
- limit=0 up one-shot → tc and done one cycle after the start edge. A start asserted in DONE restarts with newly latched limit=2 and reloads cleared.
